// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner: the hold-FSM
// state encoding, 50 MHz board defaults and the counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } hold_state_e;

  localparam int unsigned DEF_N_BTN         = 6;
  localparam int unsigned DEF_DB_CYCLES     = 500_000;     // 10 ms
  localparam int unsigned DEF_LONG_CYCLES   = 50_000_000;  // 1 s
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;  // 200 ms

  // Width of a counter that must hold values 0 .. max(a,b)-1.
  function automatic int cnt_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_if.sv
// Button bundle between the board pins and the conditioner outputs.
// The conditioner takes the slave side; the board/bench drives the master side.
interface btn_if #(
  parameter int N_BTN = 6
) ();

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  logic [N_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long,
    input  btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long,
    output btn_repeat
  );

endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, consecutive-cycle debounce and the
// IDLE/HELD/LONG hold FSM. Auto-repeat counting exists only with AUTOREPEAT_EN.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic raw,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DB_W   = $clog2(DB_CYCLES);
  localparam int HOLD_W = cnt_w(LONG_CYCLES, REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
`ifdef AUTOREPEAT_EN
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              level_q, level_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  hold_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`ifdef AUTOREPEAT_EN
  logic              repeat_q, repeat_d;
`endif

  logic differs;
  logic accept;

  always_comb begin
    sync1_d    = raw;
    sync2_d    = sync1_q;
    level_d    = level_q;
    db_cnt_d   = '0;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
`ifdef AUTOREPEAT_EN
    repeat_d   = 1'b0;
`endif

    differs = (sync2_q != level_q);
    accept  = differs && (db_cnt_q == DB_LAST);

    // Strobes are computed here so they register on the same edge as the level.
    if (accept) begin
      level_d   = ~level_q;
      press_d   = ~level_q;
      release_d = level_q;
    end else if (differs) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (press_d) state_d = HELD;
      end
      HELD: begin
        if (release_d) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          long_d     = 1'b1;
          hold_cnt_d = '0;
          state_d    = LONG;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      LONG: begin
        if (release_d) begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end else begin
`ifdef AUTOREPEAT_EN
          if (hold_cnt_q == REP_LAST) begin
            repeat_d   = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`else
          hold_cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      level_q    <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      state_q    <= IDLE;
      hold_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      level_q    <= level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

`ifdef AUTOREPEAT_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) repeat_q <= 1'b0;
    else       repeat_q <= repeat_d;
  end
  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/button_conditioner.sv
// Parameterised front end for all push buttons: one btn_channel per pin.
// Define AUTOREPEAT_EN to enable btn_repeat strobes; otherwise they are tied 0.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN         = DEF_N_BTN,
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input logic CLK,
  input logic RSTN,
  btn_if.slave bus
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] long_w;
  logic [N_BTN-1:0] repeat_w;

  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .raw      (bus.btn_raw[i]),
      .level_o  (level_w[i]),
      .press_o  (press_w[i]),
      .release_o(release_w[i]),
      .long_o   (long_w[i]),
      .repeat_o (repeat_w[i])
    );
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.btn_long    = long_w;
  assign bus.btn_repeat  = repeat_w;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end input stage for the clock/stopwatch top level. Sits directly upstream of the FSM, stopwatch and lap logic.
- Takes N_BTN raw, chattering, asynchronous push-button inputs (mode, set, up, down, lap, reset).
- Produces per button:
  - synchronized, debounced levels;
  - single-cycle press and release strobes;
  - a long-press strobe;
  - optional auto-repeat strobes for held up/down buttons.
- Replaces the per-button stabilizer instances with one parameterised block.

Parameters:
- N_BTN, 6, number of button channels.
- DB_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Must be ≥ 2.
- LONG_CYCLES, 50000000, held cycles after the press strobe before the long-press strobe fires (1 s). Must be > DB_CYCLES.
- REPEAT_CYCLES, 10000000, auto-repeat period after the long press (200 ms). Used only with AUTOREPEAT_EN.

Ports:
- CLK  input  1  system clock. All logic is on the rising edge.
- RSTN  input  1  reset, asynchronous assert, active-low.
- btn_raw  input  N_BTN  raw button pins, active-high, asynchronous to CLK.
- btn_level  output  N_BTN  debounced level, registered.
- btn_press  output  N_BTN  one-cycle strobe on accepted 0→1.
- btn_release  output  N_BTN  one-cycle strobe on accepted 1→0.
- btn_long  output  N_BTN  one-cycle strobe when a hold reaches LONG_CYCLES.
- btn_repeat  output  N_BTN  one-cycle auto-repeat strobes. Tied 0 when AUTOREPEAT_EN is undefined.

Behaviour:
- Reset (RSTN=0, asynchronous):
  - all synchronizer flops, counters and FSMs cleared;
  - all outputs 0; FSM state IDLE.
- Synchronizer: 2-flop, per bit. sync[i] lags btn_raw[i] by 2 rising edges.
- Debounce, per channel:
  - db_cnt counts consecutive cycles with sync != btn_level.
  - Any cycle with sync == btn_level clears db_cnt.
  - When db_cnt == DB_CYCLES-1 and sync still differs: on that edge btn_level toggles and db_cnt clears.
  - Latency from a clean raw edge to the btn_level change: DB_CYCLES+2 edges.
  - A glitch shorter than DB_CYCLES cycles never changes btn_level.
- Strobes are registered and aligned to the btn_level transition edge:
  - btn_press=1 in the same cycle btn_level first reads 1;
  - btn_release=1 in the same cycle btn_level first reads 0.
  - Each strobe is exactly 1 cycle wide.
- Hold FSM, per channel:
  - States: IDLE, HELD, LONG.
  - IDLE→HELD on accepted press. hold_cnt=0.
  - HELD: hold_cnt increments each cycle. When hold_cnt reaches LONG_CYCLES-1, btn_long pulses, hold_cnt clears, and the FSM moves to LONG.
  - HELD→IDLE on accepted release. No btn_long.
  - LONG: hold_cnt counts modulo REPEAT_CYCLES. btn_repeat pulses on each wrap, i.e. first repeat REPEAT_CYCLES cycles after btn_long.
  - LONG→IDLE on accepted release. The counter clears.
- Widths:
  - db_cnt is $clog2(DB_CYCLES) bits;
  - hold_cnt is $clog2(max(LONG_CYCLES, REPEAT_CYCLES)) bits.
  - Neither counter wraps uncontrolled; both are explicitly cleared.
- Boundary cases:
  - Release accepted in the same cycle hold_cnt would hit terminal: release wins; no btn_long and no btn_repeat that cycle.
  - Simultaneous events on different channels are fully independent; multiple strobe bits may be high together.
  - Reset asserted mid-hold or mid-debounce: the channel returns to IDLE with btn_level=0. If the pin is still pressed after reset, a fresh press is accepted after DB_CYCLES+2 cycles.
  - btn_long and btn_press are never high in the same cycle.

Optional Feature:
- AUTOREPEAT_EN defined:
  - LONG state runs the repeat counter;
  - btn_repeat pulses every REPEAT_CYCLES while held.
- AUTOREPEAT_EN undefined:
  - LONG is a terminal hold state with no counting;
  - btn_repeat is constant 0 and the repeat logic is removed.

Decomposition:
- Shared package btn_pkg holds:
  - the hold-FSM state typedef (IDLE, HELD, LONG);
  - default cycle constants for the 50 MHz board;
  - a helper for the counter-width function.
- One sub-module, btn_channel: synchronizer, debounce and hold FSM for a single button. Instantiated N_BTN times in a generate loop.
- The top level only fans out bits and concatenates outputs.

Test Plan:
All scenarios use DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5.
1. Clean press on btn_raw[0] at cycle 10, held:
   - btn_level[0] rises at cycle 16, with btn_press[0] high for exactly cycle 16;
   - btn_long[0] at cycle 36.
2. Chatter: btn_raw[1] toggles every 2 cycles for 20 cycles, then stays 0 → btn_level[1] never rises; no strobes.
3. Short tap, 10 cycles high → one btn_press and one btn_release, 10 cycles apart; btn_long stays 0.
4. AUTOREPEAT_EN defined, hold btn_raw[2] for 60 cycles:
   - btn_long once;
   - btn_repeat at +5, +10, +15 … after btn_long until the release is accepted.
   - Rebuild without the macro → btn_repeat stays 0.
5. Hold btn_raw[3] and assert RSTN=0 for 3 cycles mid-HELD:
   - all outputs 0 immediately (async);
   - after release of reset with the pin still high, btn_press[3] fires 6 cycles later.
6. Press channels 0 and 5 on the same cycle → both btn_press bits high in the same cycle; long strobes coincide.
